// File: rtl/display_hexa_n.sv
// display_hexa_n
// N-digit hexadecimal driver for an active-low seven-segment bank.
// A value is captured on a load strobe. Each nibble is decoded to a glyph,
// and the segment pattern is presented on a registered output bus.
// Optional features are leading-zero suppression, a global enable and
// per-digit blinking. The blink divider exists only when the macro
// DISPLAY_BLINK_EN is defined. Without it the blink phase is held at 0
// and piscar has no effect.
//
// Parameters:
//   N_DIGITS    number of digits (1..8)
//   BLINK_DIV   clock cycles per blink half-period (>= 2)
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   carrega      load strobe for dado
//   dado         4*N_DIGITS value; nibble i drives digit i
//   habilita     1 = show digits, 0 = blank all digits
//   apaga_zeros  1 = suppress leading zeros (digit 0 always shown)
//   piscar       per-digit blink mask
//   displays     7*N_DIGITS active-low segments; digit i on bits 7i+6:7i
module display_hexa_n #(
  parameter int N_DIGITS  = 6,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    carrega,
  input  logic [4*N_DIGITS-1:0]   dado,
  input  logic                    habilita,
  input  logic                    apaga_zeros,
  input  logic [N_DIGITS-1:0]     piscar,
  output logic [7*N_DIGITS-1:0]   displays
);

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // Reject parameter values that the digit and divider logic cannot support.
  if ((N_DIGITS < 1) || (N_DIGITS > 8) || (BLINK_DIV < 2)) begin : g_param_check
    $error("display_hexa_n: N_DIGITS must be 1..8 and BLINK_DIV must be >= 2");
  end

  // Active-low glyph for one hex nibble. Segment a is bit 0 and g is bit 6.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = GLYPH_BLANK;
    endcase
    return seg;
  endfunction

  logic [4*N_DIGITS-1:0] valor_r;
  logic [7*N_DIGITS-1:0] displays_r;
  logic [7*N_DIGITS-1:0] disp_s;
  logic [N_DIGITS-1:0]   lead_s;
  logic                  lead_run_s;
  logic                  fase_s;

  // Value register: captures dado on the load strobe and holds otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_r <= '0;
    end else if (carrega) begin
      valor_r <= dado;
    end else begin
      valor_r <= valor_r;
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int CW = $clog2(BLINK_DIV);

  logic [CW-1:0] cont_r;
  logic          fase_r;

  // Blink divider: cont wraps after BLINK_DIV cycles, and fase toggles on the wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont_r <= '0;
      fase_r <= 1'b0;
    end else if (cont_r == CW'(BLINK_DIV - 1)) begin
      cont_r <= '0;
      fase_r <= ~fase_r;
    end else begin
      cont_r <= cont_r + CW'(1);
      fase_r <= fase_r;
    end
  end

  assign fase_s = fase_r;
`else
  assign fase_s = 1'b0;
`endif

  // Leading-zero run. lead_s[i] is set when every nibble from the top down to i is zero.
  always_comb begin
    lead_run_s = 1'b1;
    lead_s     = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      lead_run_s = lead_run_s & (valor_r[4*i +: 4] == 4'h0);
      lead_s[i]  = lead_run_s;
    end
  end

  // Next segment pattern per digit. The enable takes precedence over zero and blink blanking.
  always_comb begin
    disp_s = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!habilita) begin
        disp_s[7*i +: 7] = GLYPH_BLANK;
      end else if ((apaga_zeros && lead_s[i] && (i != 0)) || (fase_s && piscar[i])) begin
        disp_s[7*i +: 7] = GLYPH_BLANK;
      end else begin
        disp_s[7*i +: 7] = hex_glyph(valor_r[4*i +: 4]);
      end
    end
  end

  // Output register. Reset clears it to all segments off.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      displays_r <= '1;
    end else begin
      displays_r <= disp_s;
    end
  end

  assign displays = displays_r;

endmodule

// File: tb/tb_display_hexa_n.sv
module tb_display_hexa_n;

  localparam int ND = 4;
  localparam int BD = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                carrega = 1'b0;
  logic [4*ND-1:0]     dado = '0;
  logic                habilita = 1'b1;
  logic                apaga_zeros = 1'b0;
  logic [ND-1:0]       piscar = '0;
  logic [7*ND-1:0]     displays;

  int checks = 0;
  int failures = 0;

  // Reference model state and scoreboard
  logic [4*ND-1:0] m_valor = '0;
  int              m_edges = 0;
  logic [7*ND-1:0] sb_q[$];

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  display_hexa_n #(.N_DIGITS(ND), .BLINK_DIV(BD)) dut (
    .clock(clock), .reset(reset), .carrega(carrega), .dado(dado),
    .habilita(habilita), .apaga_zeros(apaga_zeros), .piscar(piscar),
    .displays(displays));

  always #5 clock = ~clock;

  // Blink phase after n edges since reset release. The phase toggles every BD edges.
  function automatic logic m_fase(input int n);
`ifdef DISPLAY_BLINK_EN
    return ((n / BD) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7*ND-1:0] model_disp(input logic [4*ND-1:0] v, input logic hab,
                                                 input logic apz, input logic [ND-1:0] pis,
                                                 input logic fase);
    logic [7*ND-1:0] r;
    logic lead;
    logic [3:0] nib;
    r = '1;
    lead = 1'b1;
    for (int i = ND - 1; i >= 0; i--) begin
      nib = v[4*i +: 4];
      lead = lead && (nib == 4'h0);
      if (!hab || (apz && lead && i != 0) || (fase && pis[i]))
        r[7*i +: 7] = BLANK;
      else
        r[7*i +: 7] = glyph_tab[nib];
    end
    return r;
  endfunction

  // Push the pattern expected after the coming edge, advance the model, take the edge.
  task automatic clk_edge();
    sb_q.push_back(model_disp(m_valor, habilita, apaga_zeros, piscar, m_fase(m_edges)));
    if (carrega) m_valor = dado;
    m_edges++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [7*ND-1:0] exp;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (displays !== {7*ND{1'b1}}) begin
      failures++;
      $display("FAIL reset_blank actual=%b required=%b", displays, {7*ND{1'b1}});
    end
    reset = 1'b0;
    m_valor = '0;
    m_edges = 0;
    clk_edge();
    exp = sb_q.pop_front();
    checks++;
    if (displays !== exp || displays !== {4{7'b1000000}}) begin
      failures++;
      $display("FAIL reset_first_edge actual=%b required=%b", displays, {4{7'b1000000}});
    end
  endtask

  task automatic test_load();
    logic [7*ND-1:0] exp;
    dado = 16'h8F10;
    carrega = 1'b1;
    clk_edge();
    carrega = 1'b0;
    exp = sb_q.pop_front();
    checks++;
    if (displays !== exp) begin
      failures++;
      $display("FAIL load_edge_k actual=%b required=%b", displays, exp);
    end
    clk_edge();
    exp = sb_q.pop_front();
    checks++;
    if (displays !== exp || displays !== {7'b0000000, 7'b0001110, 7'b1111001, 7'b1000000}) begin
      failures++;
      $display("FAIL load_8F10 actual=%b required=%b", displays, exp);
    end
  endtask

  task automatic test_zeros();
    logic [7*ND-1:0] exp;
    logic [4*ND-1:0] vals [4] = '{16'h0050, 16'h0000, 16'h0800, 16'h0001};
    apaga_zeros = 1'b1;
    foreach (vals[k]) begin
      dado = vals[k];
      carrega = 1'b1;
      clk_edge();
      carrega = 1'b0;
      void'(sb_q.pop_front());
      clk_edge();
      exp = sb_q.pop_front();
      checks++;
      if (displays !== exp) begin
        failures++;
        $display("FAIL zeros_%h actual=%b required=%b", vals[k], displays, exp);
      end
    end
    // Explicit pattern for a zero value with suppression: only digit 0 is lit.
    checks++;
    if (model_disp(16'h0000, 1'b1, 1'b1, '0, 1'b0) !== {{3{BLANK}}, 7'b1000000}) begin
      failures++;
      $display("FAIL zeros_model_0000 actual=%b required=%b",
               model_disp(16'h0000, 1'b1, 1'b1, '0, 1'b0), {{3{BLANK}}, 7'b1000000});
    end
    apaga_zeros = 1'b0;
  endtask

  task automatic test_blink();
    logic [7*ND-1:0] exp;
    int blanks;
    int want;
    dado = 16'h1234;
    carrega = 1'b1;
    piscar = 4'b0001;
    clk_edge();
    carrega = 1'b0;
    void'(sb_q.pop_front());
    clk_edge();
    void'(sb_q.pop_front());
    blanks = 0;
    for (int c = 0; c < 4 * BD; c++) begin
      clk_edge();
      exp = sb_q.pop_front();
      checks++;
      if (displays !== exp) begin
        failures++;
        $display("FAIL blink_cycle%0d actual=%b required=%b", c, displays, exp);
      end
      if (displays[6:0] === BLANK) blanks++;
    end
`ifdef DISPLAY_BLINK_EN
    want = 2 * BD;
`else
    want = 0;
`endif
    checks++;
    if (blanks != want) begin
      failures++;
      $display("FAIL blink_blank_count actual=%0d required=%0d", blanks, want);
    end
    piscar = '0;
  endtask

  task automatic test_habilita();
    logic [7*ND-1:0] exp;
    habilita = 1'b0;
    dado = 16'hABCD;
    carrega = 1'b1;
    clk_edge();
    carrega = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) clk_edge();
      exp = sb_q.pop_front();
      checks++;
      if (displays !== exp || displays !== {7*ND{1'b1}}) begin
        failures++;
        $display("FAIL habilita_off%0d actual=%b required=%b", c, displays, {7*ND{1'b1}});
      end
    end
    habilita = 1'b1;
    clk_edge();
    exp = sb_q.pop_front();
    checks++;
    if (displays !== exp || displays !== {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}) begin
      failures++;
      $display("FAIL habilita_on actual=%b required=%b", displays, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [7*ND-1:0] exp;
    logic [4*ND-1:0] vals [4] = '{16'h1111, 16'h2E2E, 16'hC0DE, 16'h9876};
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        dado = vals[k];
        carrega = 1'b1;
      end else begin
        carrega = 1'b0;
      end
      clk_edge();
      exp = sb_q.pop_front();
      checks++;
      if (displays !== exp) begin
        failures++;
        $display("FAIL b2b_step%0d actual=%b required=%b", k, displays, exp);
      end
    end
    clk_edge();
    exp = sb_q.pop_front();
    checks++;
    if (displays !== exp) begin
      failures++;
      $display("FAIL b2b_hold actual=%b required=%b", displays, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [7*ND-1:0] exp;
    int guard;
    piscar = 4'b1111;
    dado = 16'h4321;
    carrega = 1'b1;
    clk_edge();
    carrega = 1'b0;
    void'(sb_q.pop_front());
    guard = 0;
    while (!m_fase(m_edges - 1) && guard < 3 * BD) begin
      clk_edge();
      exp = sb_q.pop_front();
      checks++;
      if (displays !== exp) begin
        failures++;
        $display("FAIL areset_pre%0d actual=%b required=%b", guard, displays, exp);
      end
      guard++;
    end
    dado = 16'hFFFF;
    carrega = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (displays !== {7*ND{1'b1}}) begin
      failures++;
      $display("FAIL areset_noclock actual=%b required=%b", displays, {7*ND{1'b1}});
    end
    @(posedge clock);
    #1;
    checks++;
    if (displays !== {7*ND{1'b1}}) begin
      failures++;
      $display("FAIL areset_held actual=%b required=%b", displays, {7*ND{1'b1}});
    end
    carrega = 1'b0;
    reset = 1'b0;
    sb_q.delete();
    m_valor = '0;
    m_edges = 0;
    for (int c = 0; c < BD; c++) begin
      clk_edge();
      exp = sb_q.pop_front();
      checks++;
      if (displays !== exp || displays !== {4{7'b1000000}}) begin
        failures++;
        $display("FAIL areset_after%0d actual=%b required=%b", c, displays, {4{7'b1000000}});
      end
    end
    piscar = '0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_zeros();
    test_blink();
    test_habilita();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_hexa_n.md
# display_hexa_n

Parametrised N-digit hexadecimal display driver for the DE0-CV seven-segment bank. It captures an N-nibble value on a load strobe and drives N active-low seven-segment digits from registered outputs. It adds optional leading-zero suppression, a global display enable and per-digit blinking from an internal divider. It sits between datapath debug buses and the HEXn pins, replacing per-digit combinational decoders.

## Interface

Parameters:
- N_DIGITS, 6, number of digits driven (1..8).
- BLINK_DIV, 25000000, clock cycles per blink half-period (>= 2); counter width = $clog2(BLINK_DIV).

Ports (clock and reset first):
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- carrega  input  1  load strobe; `dado` is captured on the rising edge where `carrega`=1.
- dado  input  4*N_DIGITS  value to display; nibble i (bits 4i+3:4i) drives digit i, and digit 0 is least significant.
- habilita  input  1  1 = show digits, 0 = all digits blank (value register still loads).
- apaga_zeros  input  1  1 = suppress leading zeros.
- piscar  input  N_DIGITS  per-digit blink mask.
- displays  output  7*N_DIGITS  segments of digit i are on bits 7i+6:7i; active-low; bit 7i+6 = segment 6 (g), bit 7i = segment 0 (a).

## Operation

- Value register `valor` (4*N_DIGITS) loads `dado` when `carrega`=1 and holds otherwise.
- Glyph encoding is active-low with segment order a..g = bits 0..6:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111.
- Leading-zero rule: digit i (i >= 1) is blanked when `apaga_zeros`=1 and every nibble from N_DIGITS-1 down to i is zero. Digit 0 is never blanked by this rule, so a value of 0 shows as a single "0".
- Blink: counter `cont` runs 0..BLINK_DIV-1 and wraps. On the wrap, `fase` toggles. While `fase`=1, every digit with `piscar[i]`=1 is blank.
- Blank precedence: `habilita`=0 blanks all digits. Otherwise a digit is blank if the leading-zero rule or the blink rule applies. Otherwise it shows its glyph.
- Output register: `displays` is registered from the rules above, evaluated on the current `valor`, `fase` and inputs.
- Reset (asynchronous): `valor`=0, `cont`=0, `fase`=0, `displays`=all ones (all blank).
- If reset is asserted mid-operation, all state clears immediately regardless of the clock. A `carrega` pulse asserted during reset is lost.

## Timing

- Load latency is 2 rising edges:
  - edge k with `carrega`=1: `valor` takes the new value.
  - edge k+1: `displays` shows it.
- `habilita`, `apaga_zeros` and `piscar` take effect on `displays` 1 edge after they change.
- Blink timing: `fase` toggles on the edge where `cont`=BLINK_DIV-1 (`cont` returns to 0 on that edge). `displays` reflects the new phase 1 edge later. The full blink period is 2*BLINK_DIV cycles.
- Back-to-back `carrega` on consecutive edges: every value is captured and each appears on `displays` for one cycle, in order.
- A load coinciding with a phase toggle has no interaction; both take effect on their nominal edges.
- First edge after reset deassert with `habilita`=1: `displays` shows "0" on every digit, or only on digit 0 if `apaga_zeros`=1.

## Configuration

- Macro `DISPLAY_BLINK_EN`.
- Defined: blink counter and `fase` are implemented as above.
- Undefined: no counter or `fase` is instantiated; `fase` is constant 0, `piscar` is ignored, and BLINK_DIV has no effect. All other behaviour is identical.

## Test plan

All scenarios use N_DIGITS=4 and BLINK_DIV=4, with `DISPLAY_BLINK_EN` defined unless stated.

- Reset, then release with `habilita`=1, `apaga_zeros`=0, `piscar`=0 -> `displays`=all ones during reset; next edge gives digits 3..0 each = 1000000.
- `carrega` pulse with `dado`=16'h8F10 -> two edges later, digit3=0000000, digit2=0001110, digit1=1111001, digit0=1000000.
- `apaga_zeros`=1:
  - `dado`=16'h0050 -> digits 3 and 2 = 1111111, digit1=0010010, digit0=1000000.
  - `dado`=16'h0000 -> only digit0 = 1000000.
- `piscar`=4'b0001 with `dado`=16'h1234 -> digit0 alternates 0011001 / 1111111 every 4 cycles (period 8); digits 3..1 remain steady. Without the macro, digit0 stays 0011001.
- `habilita`=0 while loading 16'hABCD -> all ones. Raising `habilita` to 1 -> next edge shows A,b,C,d.
- Assert reset asynchronously mid-blink and mid-load -> `displays` goes to all ones without a clock edge. After release, `valor`=0 and `fase`=0.
